// File: rtl/xspi_nor_seq.sv
// rtl/xspi_nor_seq.sv - xSPI NOR command sequencer between the slave PHY and the memory bus
module xspi_nor_seq #(
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int ADDR_BITS        = 24,
  parameter int DUMMY_CYCLES     = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sce_i,
  input  logic                        txndone_i,
  input  logic [WORD_SIZE-1:0]        txndata_i,
  output logic [CYCLE_COUNT_BITS-1:0] txnbc_o,
  output logic [1:0]                  txnmode_o,
  output logic                        txndir_o,
  output logic [WORD_SIZE-1:0]        txndata_o,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic                        req_write_o,
  output logic [ADDR_BITS-1:0]        req_addr_o,
  output logic [WORD_SIZE-1:0]        req_wdata_o,
  input  logic                        rsp_valid_i,
  input  logic [WORD_SIZE-1:0]        rsp_rdata_i,
  output logic                        err_o
);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_STAT, S_IGNORE} state_t;

  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_PROG  = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_BYTE  = CYCLE_COUNT_BITS'(8);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_ADDR  = CYCLE_COUNT_BITS'(ADDR_BITS);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_DUMMY = CYCLE_COUNT_BITS'(DUMMY_CYCLES);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_WORD  = CYCLE_COUNT_BITS'(WORD_SIZE);
  localparam logic [ADDR_BITS-1:0] ADDR_STEP  = ADDR_BITS'(WORD_SIZE / 8);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~(ADDR_STEP - ADDR_BITS'(1));

  state_t state_q, state_d;
  logic sce_meta_q, sce_sync_q, sce_prev_q;
  logic done_meta_q, done_sync_q, done_prev_q;
  logic [CYCLE_COUNT_BITS-1:0] txnbc_q, txnbc_d;
  logic [1:0]                  txnmode_q, txnmode_d;
  logic                        txndir_q, txndir_d;
  logic [WORD_SIZE-1:0]        txndata_q, txndata_d;
  logic                        req_valid_q, req_valid_d, req_write_q, req_write_d;
  logic [ADDR_BITS-1:0]        req_addr_q, req_addr_d, addr_q, addr_d, next_addr;
  logic [WORD_SIZE-1:0]        req_wdata_q, req_wdata_d, rbuf_q, rbuf_d;
  logic                        rbuf_full_q, rbuf_full_d, rd_out_q, rd_out_d;
  logic                        stale_q, stale_d, err_q, err_d;
  logic [7:0]                  cmd_q, cmd_d;
  logic                        done_evt, busy, cmd_is_read, cmd_is_quad;
  logic [7:0]                  opcode;

  assign done_evt    = done_sync_q & ~done_prev_q & sce_sync_q;
  assign busy        = req_valid_q | rd_out_q;
  assign cmd_is_read = (cmd_q == OP_FREAD) || (cmd_q == OP_QREAD);
  assign cmd_is_quad = (cmd_q == OP_QREAD);
  assign opcode      = txndata_i[7:0];
  assign next_addr   = addr_q + ADDR_STEP;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_CMD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!sce_sync_q) begin
      state_d = S_CMD;
    end else if (done_evt) begin
      unique case (state_q)
        S_CMD: begin
          if (opcode == OP_FREAD || opcode == OP_QREAD || opcode == OP_PROG) state_d = S_ADDR;
          else if (opcode == OP_RDSR)                                        state_d = S_STAT;
          else                                                               state_d = S_IGNORE;
        end
        S_ADDR:  state_d = cmd_is_read ? S_DUMMY : S_WDATA;
        S_DUMMY: state_d = S_RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  // Computes the configuration of the PHY's next transaction and any bus request for this done_evt.
  always_comb begin
    txnbc_d     = txnbc_q;
    txnmode_d   = txnmode_q;
    txndir_d    = txndir_q;
    txndata_d   = txndata_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    rbuf_d      = rbuf_q;
    rbuf_full_d = rbuf_full_q;
    rd_out_d    = rd_out_q;
    stale_d     = stale_q;
    err_d       = 1'b0;
    if (req_valid_q && req_ready_i) begin
      req_valid_d = 1'b0;
      if (!req_write_q) rd_out_d = 1'b1;
    end
    if (rsp_valid_i) rd_out_d = 1'b0;
    if (!sce_sync_q) begin
      txnbc_d     = BC_BYTE;
      txnmode_d   = 2'b00;
      txndir_d    = 1'b0;
      txndata_d   = '0;
      rbuf_full_d = 1'b0;
    end else if (done_evt) begin
      unique case (state_q)
        S_CMD: begin
          cmd_d     = opcode;
          txnmode_d = 2'b00;
          txndata_d = '0;
          txndir_d  = 1'b0;
          txnbc_d   = BC_BYTE;
          if (opcode == OP_FREAD || opcode == OP_QREAD || opcode == OP_PROG) begin
            txnbc_d = BC_ADDR;
          end else if (opcode == OP_RDSR) begin
            txndir_d                    = 1'b1;
            txndata_d[WORD_SIZE-1 -: 8] = {7'b0, busy};
          end
        end
        S_ADDR: begin
          addr_d    = txndata_i[ADDR_BITS-1:0];
          txnmode_d = 2'b00;
          txndir_d  = 1'b0;
          txnbc_d   = cmd_is_read ? BC_DUMMY : BC_WORD;
          if (cmd_is_read && !req_valid_q) begin
            req_valid_d = 1'b1;
            req_write_d = 1'b0;
            req_addr_d  = txndata_i[ADDR_BITS-1:0] & ALIGN_MASK;
          end
        end
        S_DUMMY, S_RDATA: begin
          txnbc_d   = BC_WORD;
          txnmode_d = cmd_is_quad ? 2'b10 : 2'b00;
          txndir_d  = 1'b1;
          if (rbuf_full_q) begin
            txndata_d   = rbuf_q;
            rbuf_full_d = 1'b0;
          end else begin
            txndata_d = '0;
            err_d     = 1'b1;
          end
          if (state_q == S_RDATA) begin
            addr_d = next_addr;
            if (!req_valid_q) begin
              req_valid_d = 1'b1;
              req_write_d = 1'b0;
              req_addr_d  = next_addr & ALIGN_MASK;
            end
          end
        end
        S_WDATA: begin
          if (req_valid_q) begin
            err_d = 1'b1;
          end else begin
            req_valid_d = 1'b1;
            req_write_d = 1'b1;
            req_addr_d  = addr_q & ALIGN_MASK;
            req_wdata_d = txndata_i;
            addr_d      = next_addr;
          end
        end
        S_STAT: begin
          txndata_d                   = '0;
          txndata_d[WORD_SIZE-1 -: 8] = {7'b0, busy};
        end
        default: ;
      endcase
    end
    // A response to a read issued before the last sce fall belongs to an aborted command.
    if (rsp_valid_i) begin
      if (stale_q) begin
        stale_d = 1'b0;
      end else if (sce_sync_q) begin
        rbuf_full_d = 1'b1;
        rbuf_d      = rsp_rdata_i;
      end
    end
    if (sce_prev_q && !sce_sync_q)
      stale_d = (req_valid_q && !req_write_q) || (rd_out_q && !rsp_valid_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sce_meta_q  <= 1'b0;
      sce_sync_q  <= 1'b0;
      sce_prev_q  <= 1'b0;
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
      done_prev_q <= 1'b0;
      txnbc_q     <= BC_BYTE;
      txnmode_q   <= 2'b00;
      txndir_q    <= 1'b0;
      txndata_q   <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      addr_q      <= '0;
      cmd_q       <= '0;
      rbuf_q      <= '0;
      rbuf_full_q <= 1'b0;
      rd_out_q    <= 1'b0;
      stale_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sce_meta_q  <= sce_i;
      sce_sync_q  <= sce_meta_q;
      sce_prev_q  <= sce_sync_q;
      done_meta_q <= txndone_i;
      done_sync_q <= done_meta_q;
      done_prev_q <= done_sync_q;
      txnbc_q     <= txnbc_d;
      txnmode_q   <= txnmode_d;
      txndir_q    <= txndir_d;
      txndata_q   <= txndata_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      rbuf_q      <= rbuf_d;
      rbuf_full_q <= rbuf_full_d;
      rd_out_q    <= rd_out_d;
      stale_q     <= stale_d;
      err_q       <= err_d;
    end
  end

  assign txnbc_o     = txnbc_q;
  assign txnmode_o   = txnmode_q;
  assign txndir_o    = txndir_q;
  assign txndata_o   = txndata_q;
  assign req_valid_o = req_valid_q;
  assign req_write_o = req_write_q;
  assign req_addr_o  = req_addr_q;
  assign req_wdata_o = req_wdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_xspi_nor_seq.sv
// tb/tb_xspi_nor_seq.sv - directed checks of opcode decode, read/write sequencing and error pulses
module tb_xspi_nor_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sce_i = 1'b0;
  logic        txndone_i = 1'b0;
  logic [31:0] txndata_i = '0;
  logic [5:0]  txnbc_o;
  logic [1:0]  txnmode_o;
  logic        txndir_o;
  logic [31:0] txndata_o;
  logic        req_valid_o;
  logic        req_ready_i = 1'b1;
  logic        req_write_o;
  logic [23:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_rdata_i = '0;
  logic        err_o;

  xspi_nor_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .sce_i(sce_i), .txndone_i(txndone_i), .txndata_i(txndata_i),
    .txnbc_o(txnbc_o), .txnmode_o(txnmode_o), .txndir_o(txndir_o), .txndata_o(txndata_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_write_o(req_write_o),
    .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .rsp_valid_i(rsp_valid_i),
    .rsp_rdata_i(rsp_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int log_cnt  = 0;
  logic [23:0] log_addr [16];
  logic        log_wr   [16];
  logic [31:0] log_data [16];

  always @(posedge clk_i) begin
    if (err_o) err_cnt <= err_cnt + 1;
    if (req_valid_o && req_ready_i && log_cnt < 16) begin
      log_addr[log_cnt] <= req_addr_o;
      log_wr[log_cnt]   <= req_write_o;
      log_data[log_cnt] <= req_wdata_o;
      log_cnt           <= log_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0]  op;
    logic [5:0]  bc;
    logic [1:0]  mode;
    logic        dir;
    logic [31:0] data;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic phy_txn(input logic [31:0] d);
    txndata_i = d;
    repeat (2) @(negedge clk_i);
    txndone_i = 1'b1;
    repeat (4) @(negedge clk_i);
    txndone_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic set_sce(input logic v);
    sce_i = v;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic rsp_pulse(input logic [31:0] d);
    rsp_rdata_i = d;
    rsp_valid_i = 1'b1;
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_defaults(input string tag);
    check({tag, " bc"}, 32'(txnbc_o), 32'd8);
    check({tag, " mode"}, 32'(txnmode_o), 32'd0);
    check({tag, " dir"}, 32'(txndir_o), 32'd0);
    check({tag, " data"}, txndata_o, 32'h0);
  endtask

  int e0, l0;

  initial begin
    vecs[0] = '{8'h0B, 6'd24, 2'b00, 1'b0, 32'h0};
    vecs[1] = '{8'h6B, 6'd24, 2'b00, 1'b0, 32'h0};
    vecs[2] = '{8'h02, 6'd24, 2'b00, 1'b0, 32'h0};
    vecs[3] = '{8'h05, 6'd8,  2'b00, 1'b1, 32'h0};
    vecs[4] = '{8'h9F, 6'd8,  2'b00, 1'b0, 32'h0};
    vecs[5] = '{8'h00, 6'd8,  2'b00, 1'b0, 32'h0};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_defaults("reset");
    check("reset req_valid", 32'(req_valid_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);

    for (int i = 0; i < 6; i++) begin
      set_sce(1'b1);
      phy_txn(32'(vecs[i].op));
      check($sformatf("op%h bc", vecs[i].op), 32'(txnbc_o), 32'(vecs[i].bc));
      check($sformatf("op%h mode", vecs[i].op), 32'(txnmode_o), 32'(vecs[i].mode));
      check($sformatf("op%h dir", vecs[i].op), 32'(txndir_o), 32'(vecs[i].dir));
      check($sformatf("op%h data", vecs[i].op), txndata_o, vecs[i].data);
      set_sce(1'b0);
      check_defaults($sformatf("op%h abort", vecs[i].op));
    end

    // Status register repeats with dir=1 on every byte.
    set_sce(1'b1);
    phy_txn(32'h05);
    phy_txn(32'h0);
    check("stat repeat dir", 32'(txndir_o), 32'd1);
    check("stat repeat bc", 32'(txnbc_o), 32'd8);
    set_sce(1'b0);

    // Fast read 0x0B from 0x000100.
    e0 = err_cnt; l0 = log_cnt;
    set_sce(1'b1);
    phy_txn(32'h0B);
    phy_txn(32'h0000_0100);
    check("0B req count", 32'(log_cnt - l0), 32'd1);
    check("0B req addr", 32'(log_addr[l0]), 32'h000100);
    check("0B req write", 32'(log_wr[l0]), 32'd0);
    check("0B dummy bc", 32'(txnbc_o), 32'd8);
    rsp_pulse(32'hDEAD_BEEF);
    phy_txn(32'h0);
    check("0B txdata", txndata_o, 32'hDEAD_BEEF);
    check("0B bc", 32'(txnbc_o), 32'd32);
    check("0B mode", 32'(txnmode_o), 32'd0);
    check("0B dir", 32'(txndir_o), 32'd1);
    check("0B no err", 32'(err_cnt - e0), 32'd0);
    set_sce(1'b0);

    // Quad read 0x6B from 0xFFFFFC: prefetch wraps to 0.
    l0 = log_cnt;
    set_sce(1'b1);
    phy_txn(32'h6B);
    phy_txn(32'h00FF_FFFC);
    check("6B req addr", 32'(log_addr[l0]), 32'hFFFFFC);
    rsp_pulse(32'hCAFE_F00D);
    phy_txn(32'h0);
    check("6B txdata", txndata_o, 32'hCAFE_F00D);
    check("6B mode", 32'(txnmode_o), 32'd2);
    check("6B dir", 32'(txndir_o), 32'd1);
    phy_txn(32'h0);
    check("6B req2 count", 32'(log_cnt - l0), 32'd2);
    check("6B req2 addr", 32'(log_addr[l0 + 1]), 32'h000000);
    check("6B mode word2", 32'(txnmode_o), 32'd2);
    set_sce(1'b0);

    // Late response to the aborted 0x6B must be dropped; then 0x0B with no response underruns.
    set_sce(1'b1);
    rsp_pulse(32'h1234_5678);
    e0 = err_cnt;
    phy_txn(32'h0B);
    phy_txn(32'h0000_0200);
    phy_txn(32'h0);
    check("underrun txdata", txndata_o, 32'h0);
    check("underrun err", 32'(err_cnt - e0), 32'd1);
    check("underrun bc", 32'(txnbc_o), 32'd32);
    txndata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    set_sce(1'b0);
    check_defaults("mid-word abort");
    rsp_pulse(32'h0BAD_0BAD);

    // Page program with ready tied high.
    e0 = err_cnt; l0 = log_cnt;
    set_sce(1'b1);
    phy_txn(32'h02);
    phy_txn(32'h0000_0010);
    phy_txn(32'h1122_3344);
    phy_txn(32'h5566_7788);
    check("02 req count", 32'(log_cnt - l0), 32'd2);
    check("02 w0 addr", 32'(log_addr[l0]), 32'h000010);
    check("02 w0 data", log_data[l0], 32'h1122_3344);
    check("02 w0 write", 32'(log_wr[l0]), 32'd1);
    check("02 w1 addr", 32'(log_addr[l0 + 1]), 32'h000014);
    check("02 w1 data", log_data[l0 + 1], 32'h5566_7788);
    check("02 no err", 32'(err_cnt - e0), 32'd0);
    set_sce(1'b0);

    // Page program with the bus stalled: second word overruns.
    e0 = err_cnt; l0 = log_cnt;
    req_ready_i = 1'b0;
    set_sce(1'b1);
    phy_txn(32'h02);
    phy_txn(32'h0000_0010);
    phy_txn(32'hAAAA_0001);
    check("stall valid", 32'(req_valid_o), 32'd1);
    check("stall addr", 32'(req_addr_o), 32'h000010);
    phy_txn(32'hBBBB_0002);
    check("overrun err", 32'(err_cnt - e0), 32'd1);
    check("overrun held data", req_wdata_o, 32'hAAAA_0001);
    set_sce(1'b0);
    check("held across abort", 32'(req_valid_o), 32'd1);
    req_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("held accepted", 32'(req_valid_o), 32'd0);
    check("held log count", 32'(log_cnt - l0), 32'd1);
    check("held log data", log_data[l0], 32'hAAAA_0001);

    // Reset with a write pending clears it immediately.
    req_ready_i = 1'b0;
    set_sce(1'b1);
    phy_txn(32'h02);
    phy_txn(32'h0000_0040);
    phy_txn(32'h0F0F_0F0F);
    check("pre-reset valid", 32'(req_valid_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("post-reset valid", 32'(req_valid_o), 32'd0);
    check("post-reset bc", 32'(txnbc_o), 32'd8);
    sce_i = 1'b0;
    req_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
